// File: rtl/pwm_ramp_ctrl.sv
// PWM generator whose duty slews toward a requested target once per period.
// Define PWM_RAMP_CTRL_RAMP_EN to ramp by step_in; otherwise the target is applied in one jump.
module pwm_ramp_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [WIDTH-1:0] period_in,
  input  logic [WIDTH-1:0] step_in,
  input  logic [WIDTH-1:0] tgt_in,
  input  logic             tgt_valid_in,
  output logic             tgt_ready_out,
  output logic [WIDTH-1:0] dc_out,
  output logic             sig_out,
  output logic             period_start_out,
  output logic             busy_out,
  output logic             done_out
);

  typedef enum logic {IDLE = 1'b0, RAMP = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_dc, w_dc_nxt;
  logic [WIDTH-1:0] r_tgt_q, w_tgt_nxt;
  logic             r_pstart;
  logic             r_done, w_done_nxt;
  logic             w_wrap;
  logic             w_close;
  logic [WIDTH-1:0] w_ramp_dc;

  // >= rather than == so a period shortened below cnt wraps immediately.
  assign w_wrap = (r_cnt >= period_in);

`ifdef PWM_RAMP_CTRL_RAMP_EN
  logic             w_up;
  logic [WIDTH:0]   w_step, w_diff;

  // One extra bit keeps the distance and step comparison free of wraparound.
  assign w_up      = (r_tgt_q >= r_dc);
  assign w_step    = (step_in == '0) ? (WIDTH+1)'(1) : {1'b0, step_in};
  assign w_diff    = w_up ? ({1'b0, r_tgt_q} - {1'b0, r_dc})
                          : ({1'b0, r_dc} - {1'b0, r_tgt_q});
  assign w_close   = (w_diff <= w_step);
  assign w_ramp_dc = w_up ? (r_dc + w_step[WIDTH-1:0]) : (r_dc - w_step[WIDTH-1:0]);
`else
  logic             w_unused_step;

  assign w_unused_step = ^step_in;
  assign w_close       = 1'b1;
  assign w_ramp_dc     = r_tgt_q;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
    w_state_nxt = r_state;
    w_dc_nxt    = r_dc;
    w_tgt_nxt   = r_tgt_q;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (tgt_valid_in) begin
          w_tgt_nxt   = tgt_in;
          w_state_nxt = RAMP;
        end
      end
      RAMP: begin
        if (w_wrap) begin
          if (w_close) begin
            w_dc_nxt    = r_tgt_q;
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_dc_nxt = w_ramp_dc;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_dc     <= '0;
      r_tgt_q  <= '0;
      r_pstart <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_wrap ? '0 : (r_cnt + WIDTH'(1));
      r_dc     <= w_dc_nxt;
      r_tgt_q  <= w_tgt_nxt;
      r_pstart <= w_wrap;
      r_done   <= w_done_nxt;
    end
  end

  assign tgt_ready_out    = (r_state == IDLE);
  assign busy_out         = (r_state == RAMP);
  assign dc_out           = r_dc;
  assign sig_out          = (r_cnt < r_dc);
  assign period_start_out = r_pstart;
  assign done_out         = r_done;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: a duty scoreboard is filled on each accepted
// target and drained on every period-start strobe; works with or without PWM_RAMP_CTRL_RAMP_EN.
module tb_pwm_ramp_ctrl;
  localparam int W = 32;

  logic          clk_in = 1'b0;
  logic          rst_n_in = 1'b1;
  logic [W-1:0]  period_in = '0;
  logic [W-1:0]  step_in = '0;
  logic [W-1:0]  tgt_in = '0;
  logic          tgt_valid_in = 1'b0;
  logic          tgt_ready_out;
  logic [W-1:0]  dc_out;
  logic          sig_out;
  logic          period_start_out;
  logic          busy_out;
  logic          done_out;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint exp_q[$];
  longint sb_dc = 0;

  pwm_ramp_ctrl #(.WIDTH(W)) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .period_in       (period_in),
    .step_in         (step_in),
    .tgt_in          (tgt_in),
    .tgt_valid_in    (tgt_valid_in),
    .tgt_ready_out   (tgt_ready_out),
    .dc_out          (dc_out),
    .sig_out         (sig_out),
    .period_start_out(period_start_out),
    .busy_out        (busy_out),
    .done_out        (done_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference duty sequence for one accepted target, starting from the model's current duty.
  function automatic void sb_push(input longint tgt, input longint step);
`ifdef PWM_RAMP_CTRL_RAMP_EN
    longint s;
    longint d;
    longint diff;
    s    = (step == 0) ? 1 : step;
    d    = sb_dc;
    diff = (tgt >= d) ? tgt - d : d - tgt;
    while (diff > s) begin
      d    = (tgt >= d) ? d + s : d - s;
      exp_q.push_back(d);
      diff = (tgt >= d) ? tgt - d : d - tgt;
    end
`endif
    exp_q.push_back(tgt);
    sb_dc = tgt;
  endfunction

  task automatic do_reset();
    tgt_valid_in = 1'b0;
    rst_n_in     = 1'b0;
    exp_q.delete();
    sb_dc = 0;
    #1;
    check("rst_dc",     dc_out, 0);
    check("rst_sig",    sig_out, 0);
    check("rst_ready",  tgt_ready_out, 1);
    check("rst_busy",   busy_out, 0);
    check("rst_done",   done_out, 0);
    check("rst_pstart", period_start_out, 0);
    @(negedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    check("rst_release_pstart", period_start_out, 0);
  endtask

  task automatic accept(input string tag, input longint tgt, input longint step);
    tgt_in       = W'(tgt);
    step_in      = W'(step);
    tgt_valid_in = 1'b1;
    sb_push(tgt, step);
    @(negedge clk_in);
    check({tag, "_acc_busy"},  busy_out, 1);
    check({tag, "_acc_ready"}, tgt_ready_out, 0);
    tgt_valid_in = 1'b0;
  endtask

  // Drain the scoreboard, comparing duty at each wrap; optionally keep hammering tgt_in.
  task automatic run_ramp(input string tag, input bit hold, input longint held_tgt);
    int     budget;
    longint e;
    budget = 400;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk_in);
      budget--;
      if (period_start_out) begin
        e = exp_q.pop_front();
        check({tag, "_dc"},   dc_out, e);
        check({tag, "_done"}, done_out, exp_q.size() == 0);
        if (exp_q.size() == 0) check({tag, "_busy_at_done"}, busy_out, 0);
      end else if (hold) begin
        check({tag, "_ready_held"}, tgt_ready_out, 0);
        check({tag, "_tgtq_held"},  dut.r_tgt_q, held_tgt);
      end
      if (hold && exp_q.size() > 0) tgt_in = $urandom;
    end
    if (exp_q.size() > 0) begin
      check({tag, "_timeout_pending"}, exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  initial begin
    int     ones;
    int     dones;
    int     budget;

    #2;
    period_in = 9;
    do_reset();

    // Ramp up 0 -> 10 with step 3.
    accept("up", 10, 3);
    run_ramp("up", 1'b0, 0);
    ones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in);
      if (sig_out) ones++;
    end
    check("up_sig_ones", ones, 10);

    // Ramp down 10 -> 1 with step 4.
    accept("down", 1, 4);
    run_ramp("down", 1'b0, 0);
    @(negedge clk_in);
    check("down_busy_after_done", busy_out, 0);
    check("down_done_one_cycle",  done_out, 0);
    ones = 0;
    for (int i = 0; i < 10; i++) begin
      if (sig_out) ones++;
      @(negedge clk_in);
    end
    check("down_sig_ones", ones, 1);

    // Handshake: valid held high with wandering tgt_in during the ramp.
    tgt_in       = 10;
    step_in      = 3;
    tgt_valid_in = 1'b1;
    sb_push(10, 3);
    @(negedge clk_in);
    check("hs_acc_busy", busy_out, 1);
    run_ramp("hs", 1'b1, 10);
    check("hs_ready_idle", tgt_ready_out, 1);
    tgt_in = 5;
    sb_push(5, 3);
    @(negedge clk_in);
    check("hs_next_busy", busy_out, 1);
    check("hs_next_tgtq", dut.r_tgt_q, 5);
    tgt_valid_in = 1'b0;
    run_ramp("hs2", 1'b0, 0);

    // Target equal to current duty still completes at the next boundary.
    accept("same", 5, 3);
    run_ramp("same", 1'b0, 0);

    // step_in of zero behaves as step one.
    accept("step0", 8, 0);
    run_ramp("step0", 1'b0, 0);

    // Shrinking the period below the running count wraps on the next edge.
    period_in = 20;
    budget    = 60;
    while (dut.r_cnt != 12 && budget > 0) begin
      @(negedge clk_in);
      budget--;
    end
    check("per_reach_12", dut.r_cnt, 12);
    period_in = 5;
    @(negedge clk_in);
    check("per_cnt_zero", dut.r_cnt, 0);
    check("per_pstart",   period_start_out, 1);
    period_in = 9;

    // Reset in the middle of a 6 -> 10 ramp.
    @(negedge clk_in);
    do_reset();
    accept("pre", 6, 3);
    run_ramp("pre", 1'b0, 0);
    accept("mid", 10, 3);
    @(negedge clk_in);
    @(negedge clk_in);
    check("mid_busy_before_rst", busy_out, 1);
    #2;
    do_reset();
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_in);
      if (done_out) dones++;
    end
    check("mid_no_done", dones, 0);
    check("mid_dc_zero", dc_out, 0);
    check("mid_idle",    tgt_ready_out, 1);

    // Jump 0 -> 7 (single step without the ramp feature).
    accept("seven", 7, 3);
    run_ramp("seven", 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_ramp_ctrl.md
PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the width of the counter, period, duty and step.
REQ-002 SHALL have port clk_in  input  1  system clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst_n_in  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port period_in  input  WIDTH  last count value of a PWM period, so the period is period_in+1 cycles.
REQ-005 SHALL have port step_in  input  WIDTH  duty change applied per period while ramping.
REQ-006 SHALL have port tgt_in  input  WIDTH  requested target duty, in cycles high per period.
REQ-007 SHALL have port tgt_valid_in  input  1  tgt_in is valid.
REQ-008 SHALL have port tgt_ready_out  output  1  block can accept a target.
REQ-009 SHALL have port dc_out  output  WIDTH  duty currently applied.
REQ-010 SHALL have port sig_out  output  1  PWM output.
REQ-011 SHALL have port period_start_out  output  1  one-cycle strobe in each cycle where the counter has just wrapped to 0.
REQ-012 SHALL have port busy_out  output  1  high while in state RAMP.
REQ-013 SHALL have port done_out  output  1  one-cycle strobe in the cycle dc_out first equals the target.

Function
REQ-014 SHALL hold a counter cnt that increments every cycle and loads 0 on the cycle after cnt>=period_in.
- Because the test is >=, lowering period_in below cnt mid-period wraps cnt on the next cycle.
REQ-015 SHALL drive sig_out = (cnt < dc_out) combinationally from registered cnt and dc_out.
- Any dc_out > period_in gives a constant high output; dc_out=0 gives a constant low output.
REQ-016 SHALL implement an FSM with exactly two states, IDLE and RAMP, and leave reset in IDLE.
REQ-017 SHALL drive tgt_ready_out high in IDLE and low in RAMP.
REQ-018 SHALL accept a target when tgt_valid_in and tgt_ready_out are both high on a clock edge.
- On acceptance, tgt_in is latched into tgt_q and the state moves to RAMP on that same edge.
- tgt_in is ignored at all other times.
REQ-019 SHALL define the boundary event as a RAMP cycle with cnt>=period_in; duty updates happen only at a boundary event, so each new duty takes effect together with cnt=0.
REQ-020 SHALL, at a boundary event with the ramp feature enabled, apply the following update:
- if |tgt_q-dc_out| <= step_in: dc_out=tgt_q, state goes to IDLE, done_out pulses one cycle;
- else dc_out moves toward tgt_q by exactly step_in.
REQ-021 SHALL treat step_in=0 as step 1.
REQ-022 SHALL evaluate the difference and step comparisons at WIDTH+1 bits so that no ramp overshoots or wraps.
REQ-023 SHALL ignore a boundary event in the same cycle as acceptance; the first update occurs at the next boundary after acceptance.
REQ-024 SHALL, when tgt_q equals dc_out, still enter RAMP and complete at the next boundary with a done_out pulse.
REQ-025 SHALL sample period_in and step_in live; changing them mid-ramp affects subsequent boundaries only.

Reset
REQ-026 SHALL, while rst_n_in is low, immediately force the following:
- cnt=0, dc_out=0, tgt_q=0, state=IDLE;
- sig_out=0, tgt_ready_out=1, busy_out=0, done_out=0, period_start_out=0.
REQ-027 SHALL abort any ramp in progress on reset, without generating a done_out pulse.
REQ-028 SHALL NOT pulse period_start_out in the first cycle after reset release; the first pulse comes at the first wrap.

Configuration
REQ-029 SHALL compile ramping in when macro PWM_RAMP_CTRL_RAMP_EN is defined: behaviour per REQ-020 to REQ-022.
REQ-030 SHALL, when PWM_RAMP_CTRL_RAMP_EN is undefined, set dc_out=tgt_q at the first boundary after acceptance, return to IDLE and pulse done_out; step_in is then unused.

Verification
REQ-031 SHALL cover ramp up: WIDTH=32, period_in=9, step_in=3, accept tgt=10 from dc=0.
- Required: dc_out becomes 3, 6, 9, 10 on four successive wraps; done_out pulses with the 10 update.
- Required: sig_out is high for 10 of every 10 cycles thereafter.
REQ-032 SHALL cover ramp down: from dc=10, period_in=9, step_in=4, accept tgt=1.
- Required: dc_out becomes 6, 2, 1; busy_out is low the cycle after done_out.
REQ-033 SHALL cover handshake: hold tgt_valid_in high with changing tgt_in during RAMP.
- Required: tgt_ready_out=0 and tgt_q is unchanged until IDLE; the next target is accepted in the first IDLE cycle.
REQ-034 SHALL cover period change: lower period_in from 20 to 5 while cnt=12.
- Required: cnt reads 0 on the next cycle and period_start_out pulses.
REQ-035 SHALL cover reset mid-ramp: assert rst_n_in low while dc=6 ramping toward 10.
- Required: all outputs take their reset values within the same cycle, and no done_out pulse occurs.
REQ-036 SHALL cover the build without PWM_RAMP_CTRL_RAMP_EN: accept tgt=7 with dc=0.
- Required: dc_out=7 at the first wrap, with done_out pulsing at the same time.
